// File: rtl/load_store_unit.sv
// Load/store initiator for a 64x32 data memory: byte/half/word accesses, sub-word stores by read-modify-write.
// Define MISALIGN_TRAP_EN to trap misaligned halves/words and the reserved size with RespError.
module load_store_unit #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W+1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqWData,
    output logic              RespValid,
    output logic [DATA_W-1:0] RespData,
    output logic              RespError,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    output logic              MemoryRead,
    output logic              MemoryWrite,
    input  logic [DATA_W-1:0] ReadData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RWAIT,
`ifdef MISALIGN_TRAP_EN
        S_RESP_ERR,
`endif
        S_WR
    } state_e;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          lane_q, lane_d;
    logic [1:0]          size_q, size_d;
    logic                sgn_q, sgn_d;
    logic                write_q, write_d;
    logic [15:0]         sdata_q, sdata_d;
    logic                misalign_s;

    // Selects the addressed lane of a word and extends it to 32 bits; size 11 acts as a word.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic sgn);
        logic [31:0] res;
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = {{24{sgn & b[7]}}, b};
            2'b01:   res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replaces one byte or half lane of a word, leaving the other lanes intact.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic [15:0] data);
        logic [31:0] res;
        res = word;
        case (size)
            2'b00: res[{lane, 3'b000} +: 8] = data[7:0];
            2'b01: begin
                if (lane[1]) res[31:16] = data;
                else         res[15:0]  = data;
            end
            default: res = word;
        endcase
        return res;
    endfunction

`ifdef MISALIGN_TRAP_EN
    logic rerr_q, rerr_d;
    assign misalign_s = (ReqSize == 2'b11) ||
                        ((ReqSize == 2'b01) && ReqAddr[0]) ||
                        ((ReqSize == 2'b10) && (ReqAddr[1:0] != 2'b00));
    assign RespError  = rerr_q;
`else
    assign misalign_s = 1'b0;
    assign RespError  = 1'b0;
`endif

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b0;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        rvalid_d = 1'b0;
        rdata_d  = {DATA_W{1'b0}};
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lane_d   = lane_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        write_d  = write_q;
        sdata_d  = sdata_q;
`ifdef MISALIGN_TRAP_EN
        rerr_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (ReqValid) begin
                    addr_d  = ReqAddr[ADDR_W+1:2];
                    lane_d  = ReqAddr[1:0];
                    size_d  = ReqSize;
                    sgn_d   = ReqSigned;
                    write_d = ReqWrite;
                    sdata_d = ReqWData[15:0];
                    if (misalign_s) begin
`ifdef MISALIGN_TRAP_EN
                        state_d = S_RESP_ERR;
`else
                        state_d = S_IDLE;
                        ready_d = 1'b1;
`endif
                    end else if (ReqWrite && ReqSize[1]) begin
                        // Full-word stores skip the read phase entirely.
                        state_d = S_WR;
                        wr_d    = 1'b1;
                        wdata_d = ReqWData;
                    end else begin
                        state_d = S_RD;
                        rd_d    = 1'b1;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_RD: begin
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (write_q) begin
                    state_d = S_WR;
                    wr_d    = 1'b1;
                    wdata_d = store_merge(ReadData, lane_q, size_q, sdata_q);
                end else begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b1;
                    rvalid_d = 1'b1;
                    rdata_d  = load_extend(ReadData, lane_q, size_q, sgn_q);
                end
            end
            S_WR: begin
                state_d  = S_IDLE;
                ready_d  = 1'b1;
                rvalid_d = 1'b1;
            end
`ifdef MISALIGN_TRAP_EN
            S_RESP_ERR: begin
                state_d  = S_IDLE;
                ready_d  = 1'b1;
                rvalid_d = 1'b1;
                rerr_d   = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= {DATA_W{1'b0}};
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
            lane_q   <= 2'b00;
            size_q   <= 2'b00;
            sgn_q    <= 1'b0;
            write_q  <= 1'b0;
            sdata_q  <= 16'h0000;
`ifdef MISALIGN_TRAP_EN
            rerr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            write_q  <= write_d;
            sdata_q  <= sdata_d;
`ifdef MISALIGN_TRAP_EN
            rerr_q   <= rerr_d;
`endif
        end
    end

    assign ReqReady    = ready_q;
    assign RespValid   = rvalid_q;
    assign RespData    = rdata_q;
    assign Address     = addr_q;
    assign WriteData   = wdata_q;
    assign MemoryRead  = rd_q;
    assign MemoryWrite = wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed spec cases plus random requests checked against a lane-arithmetic model.
module tb_load_store_unit;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqWrite = 1'b0;
    logic [1:0]  ReqSize = 2'b00;
    logic        ReqSigned = 1'b0;
    logic [7:0]  ReqAddr = 8'h00;
    logic [31:0] ReqWData = 32'h0;
    logic        ReqReady, RespValid, RespError, MemoryRead, MemoryWrite;
    logic [31:0] RespData, WriteData;
    logic [31:0] ReadData = 32'h0;
    logic [5:0]  Address;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx = 6'd0;
    logic [31:0] bd_val = 32'h0;
    logic [31:0] last_data;
    int          n_chk = 0;
    int          n_pass = 0;

    load_store_unit dut (
        .Clock(Clock), .ResetN(ResetN), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr),
        .ReqWData(ReqWData), .RespValid(RespValid), .RespData(RespData), .RespError(RespError),
        .Address(Address), .WriteData(WriteData), .MemoryRead(MemoryRead),
        .MemoryWrite(MemoryWrite), .ReadData(ReadData)
    );

    always #5 Clock = ~Clock;

    // Memory: read sampled on the rising edge, writes on the falling edge, plus a preload port.
    always @(posedge Clock) if (MemoryRead) ReadData <= mem[Address];
    always @(negedge Clock) begin
        if (bd_we)            mem[bd_idx]  <= bd_val;
        else if (MemoryWrite) mem[Address] <= WriteData;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    // Issue one request, follow it to its response and compare against the model.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [7:0] a, input logic [31:0] wd);
        logic [31:0] word, mask, v, newv, exp_data;
        logic        trap, exp_err, got_err;
        int          eff, nb, sh, exp_n, exp_rd, exp_wr;
        int          n, rd_c, wr_c, both_c, bad_addr, bad_wd;
        eff  = (sz == 2'd3) ? 2 : int'(sz);
        nb   = 8 << eff;
        sh   = (eff == 0) ? 8 * int'(a[1:0]) : ((eff == 1) ? 16 * int'(a[1]) : 0);
        mask = (nb == 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
        word = ref_mem[a[7:2]];
`ifdef MISALIGN_TRAP_EN
        trap = (sz == 2'd3) || ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'd0));
`else
        trap = 1'b0;
`endif
        newv = word; exp_data = 32'h0; exp_err = 1'b0;
        if (trap) begin
            exp_n = 1; exp_rd = 0; exp_wr = 0; exp_err = 1'b1;
        end else if (!wr) begin
            exp_n = 2; exp_rd = 1; exp_wr = 0;
            v = (word >> sh) & mask;
            if (sg && nb < 32 && v[nb-1]) v = v | ~mask;
            exp_data = v;
        end else begin
            newv   = (word & ~(mask << sh)) | ((wd & mask) << sh);
            exp_wr = 1;
            exp_rd = (nb < 32) ? 1 : 0;
            exp_n  = (nb < 32) ? 3 : 1;
        end

        @(negedge Clock);
        chk("ready_idle", {31'h0, ReqReady}, 32'h1);
        ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = wd;
        @(posedge Clock); #1;
        // Keep ReqValid high with junk fields: the unit must ignore them while busy.
        ReqWrite = 1'($urandom); ReqSize = 2'($urandom); ReqSigned = 1'($urandom);
        ReqAddr = 8'($urandom); ReqWData = $urandom;
        n = 99; rd_c = 0; wr_c = 0; both_c = 0; bad_addr = 0; bad_wd = 0;
        last_data = 32'hDEAD_0000; got_err = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin @(posedge Clock); #1; end
            if (MemoryRead) begin
                rd_c++;
                if (Address != a[7:2]) bad_addr++;
            end
            if (MemoryWrite) begin
                wr_c++;
                if (Address != a[7:2]) bad_addr++;
                if (WriteData !== newv) bad_wd++;
            end
            if (MemoryRead && MemoryWrite) both_c++;
            if (RespValid) begin
                n = k; last_data = RespData; got_err = RespError;
                ReqValid = 1'b0;
                break;
            end
        end
        ReqValid = 1'b0;
        chk("latency", 32'(n), 32'(exp_n));
        chk("resp_data", last_data, exp_data);
        chk("resp_error", {31'h0, got_err}, {31'h0, exp_err});
        chk("read_strobes", 32'(rd_c), 32'(exp_rd));
        chk("write_strobes", 32'(wr_c), 32'(exp_wr));
        chk("strobe_overlap", 32'(both_c), 32'h0);
        chk("strobe_address", 32'(bad_addr), 32'h0);
        chk("write_data", 32'(bad_wd), 32'h0);
        ref_mem[a[7:2]] = newv;
        chk("mem_word", mem[a[7:2]], ref_mem[a[7:2]]);
    endtask

    initial begin
        // Reset held while the memory is preloaded through the backdoor.
        for (int i = 0; i < 64; i++) begin
            bd_idx = 6'(i);
            bd_val = (i == 5) ? 32'h8877_6655 : $urandom;
            ref_mem[i] = bd_val;
            bd_we = 1'b1;
            @(negedge Clock); #1;
        end
        bd_we = 1'b0;
        chk("rst_ready", {31'h0, ReqReady}, 32'h1);
        chk("rst_mread", {31'h0, MemoryRead}, 32'h0);
        chk("rst_mwrite", {31'h0, MemoryWrite}, 32'h0);
        chk("rst_rvalid", {31'h0, RespValid}, 32'h0);
        chk("rst_rdata", RespData, 32'h0);
        chk("rst_rerror", {31'h0, RespError}, 32'h0);
        @(negedge Clock);
        ResetN = 1'b1;

        do_req(1'b0, 2'd2, 1'b0, 8'h14, 32'h0);
        chk("word_load_value", last_data, 32'h8877_6655);
        do_req(1'b0, 2'd0, 1'b1, 8'h17, 32'h0);
        chk("byte_load_signed", last_data, 32'hFFFF_FF88);
        do_req(1'b0, 2'd0, 1'b0, 8'h17, 32'h0);
        chk("byte_load_unsigned", last_data, 32'h0000_0088);
        do_req(1'b0, 2'd1, 1'b1, 8'h16, 32'h0);
        chk("half_load_signed", last_data, 32'hFFFF_8877);
        do_req(1'b1, 2'd0, 1'b0, 8'h15, 32'h1234_56AB);
        chk("byte_store_mem5", mem[5], 32'h8877_AB55);
        do_req(1'b1, 2'd1, 1'b0, 8'h16, 32'hFFFF_1234);
        chk("half_store_mem5", mem[5], 32'h1234_AB55);
        do_req(1'b0, 2'd2, 1'b0, 8'h13, 32'h0);
        do_req(1'b0, 2'd3, 1'b1, 8'h20, 32'h0);
        do_req(1'b1, 2'd3, 1'b0, 8'h24, 32'hCAFE_F00D);

        for (int i = 0; i < 48; i++)
            do_req(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), $urandom);

        // Abort a word store by reset before its falling edge.
        @(negedge Clock);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd2; ReqSigned = 1'b0;
        ReqAddr = 8'h14; ReqWData = 32'hDEAD_BEEF;
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        chk("abort_strobe_seen", {31'h0, MemoryWrite}, 32'h1);
        #2 ResetN = 1'b0;
        #1;
        chk("abort_mwrite_low", {31'h0, MemoryWrite}, 32'h0);
        chk("abort_ready", {31'h0, ReqReady}, 32'h1);
        chk("abort_no_resp", {31'h0, RespValid}, 32'h0);
        repeat (2) @(negedge Clock);
        chk("abort_mem_kept", mem[5], ref_mem[5]);
        ResetN = 1'b1;
        do_req(1'b0, 2'd2, 1'b0, 8'h14, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
